// File: rtl/rv_sdram_requester_if.sv
// Bus bundle between the softcore memory port, the requester and the SDRAM arbiter.
// Signal names use the requester's point of view (i_ = into requester, o_ = out of it).
interface rv_sdram_requester_if #(
    parameter int unsigned ADDR_WIDTH = 23
) ();
    logic                  i_mem_valid;
    logic [ADDR_WIDTH-1:0] i_mem_addr;
    logic [31:0]           i_mem_wdata;
    logic [3:0]            i_mem_wstrb;
    logic                  o_mem_ready;
    logic [31:0]           o_mem_rdata;

    logic [ADDR_WIDTH-1:0] o_rv_addr;
    logic                  o_rv_word;
    logic [31:0]           o_rv_wdata;
    logic [1:0]            o_rv_ds;
    logic [3:0]            o_rv_wstrb;
    logic                  o_rv_req;
    logic                  i_rv_req_ack;
    logic [15:0]           i_rv_dout;

    modport master (
        input  i_mem_valid, i_mem_addr, i_mem_wdata, i_mem_wstrb,
        output o_mem_ready, o_mem_rdata,
        output o_rv_addr, o_rv_word, o_rv_wdata, o_rv_ds, o_rv_wstrb, o_rv_req,
        input  i_rv_req_ack, i_rv_dout
    );

    modport slave (
        output i_mem_valid, i_mem_addr, i_mem_wdata, i_mem_wstrb,
        input  o_mem_ready, o_mem_rdata,
        input  o_rv_addr, o_rv_word, o_rv_wdata, o_rv_ds, o_rv_wstrb, o_rv_req,
        output i_rv_req_ack, i_rv_dout
    );
endinterface

// File: rtl/rv_sdram_requester.sv
// Splits 32-bit softcore valid/ready transactions into 16-bit toggle-handshake
// requests toward the SDRAM arbiter and reassembles read data.
module rv_sdram_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_WIDTH     = 23
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    rv_sdram_requester_if.master bus,
    output logic                 o_busy,
    output logic                 o_timeout
);

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        REQ_LO,
        WAIT_LO,
        REQ_HI,
        WAIT_HI,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;

    logic                  r_rv_req;
    logic [ADDR_WIDTH-1:0] r_rv_addr;
    logic                  r_rv_word;
    logic [31:0]           r_rv_wdata;
    logic [1:0]            r_rv_ds;
    logic [3:0]            r_rv_wstrb;
    logic                  r_mem_ready;
    logic [31:0]           r_mem_rdata;
    logic                  r_timeout;
    logic [15:0]           r_tmo_cnt;

    logic                  w_done;
    logic                  w_is_read;
    logic                  w_need_hi;
    logic                  w_waiting;
    logic                  w_sync;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_issue_hi;
    logic [1:0]            w_ds;
    logic [3:0]            w_wstrb;
    logic                  w_cap_lo;
    logic                  w_cap_hi;

    assign w_done    = (bus.i_rv_req_ack == r_rv_req);
    assign w_is_read = (r_wstrb == 4'b0000);
    assign w_need_hi = w_is_read || (r_wstrb[3:2] != 2'b00);
    assign w_waiting = (r_state == WAIT_LO) || (r_state == WAIT_HI);

    always_comb begin
        w_state_nxt = r_state;
        w_sync      = 1'b0;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_issue_hi  = 1'b0;
        w_ds        = 2'b00;
        w_wstrb     = 4'b0000;
        w_cap_lo    = 1'b0;
        w_cap_hi    = 1'b0;

        case (r_state)
            SYNC: begin
                w_sync      = 1'b1;
                w_state_nxt = IDLE;
            end
            IDLE: begin
                if (bus.i_mem_valid) begin
                    w_accept = 1'b1;
                    // A write touching only the upper half skips the low request.
                    if ((bus.i_mem_wstrb == 4'b0000) || (bus.i_mem_wstrb[1:0] != 2'b00))
                        w_state_nxt = REQ_LO;
                    else
                        w_state_nxt = REQ_HI;
                end
            end
            REQ_LO: begin
                w_issue     = 1'b1;
                w_ds        = w_is_read ? 2'b11 : r_wstrb[1:0];
                w_wstrb     = {2'b00, r_wstrb[1:0]};
                w_state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (w_done) begin
                    w_cap_lo    = 1'b1;
                    w_state_nxt = w_need_hi ? REQ_HI : DONE;
                end
            end
            REQ_HI: begin
                w_issue     = 1'b1;
                w_issue_hi  = 1'b1;
                w_ds        = w_is_read ? 2'b11 : r_wstrb[3:2];
                w_wstrb     = {r_wstrb[3:2], 2'b00};
                w_state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (w_done) begin
                    w_cap_hi    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = SYNC;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= SYNC;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rv_req    <= 1'b0;
            r_rv_addr   <= '0;
            r_rv_word   <= 1'b0;
            r_rv_wdata  <= '0;
            r_rv_ds     <= '0;
            r_rv_wstrb  <= '0;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_timeout   <= 1'b0;
            r_tmo_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_ready <= (w_state_nxt == DONE);

            // Align our toggle with whatever the arbiter's ack ended up at.
            if (w_sync)
                r_rv_req <= bus.i_rv_req_ack;

            if (w_accept) begin
                r_addr  <= bus.i_mem_addr;
                r_wdata <= bus.i_mem_wdata;
                r_wstrb <= bus.i_mem_wstrb;
            end

            if (w_issue) begin
                r_rv_req   <= ~r_rv_req;
                r_rv_addr  <= r_addr & ALIGN_MASK;
                r_rv_word  <= w_issue_hi;
                r_rv_wdata <= r_wdata;
                r_rv_ds    <= w_ds;
                r_rv_wstrb <= w_wstrb;
                r_tmo_cnt  <= '0;
            end else if (w_waiting && !w_done && (r_tmo_cnt != '1)) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end

            // Sticky flag only; the toggle protocol cannot abort an outstanding request.
            if (w_waiting && !w_done && (({16'd0, r_tmo_cnt} + 32'd1) >= TIMEOUT_CYCLES))
                r_timeout <= 1'b1;

            if (w_cap_lo)
                r_mem_rdata[15:0] <= bus.i_rv_dout;
            if (w_cap_hi)
                r_mem_rdata[31:16] <= bus.i_rv_dout;
        end
    end

    assign bus.o_rv_req    = r_rv_req;
    assign bus.o_rv_addr   = r_rv_addr;
    assign bus.o_rv_word   = r_rv_word;
    assign bus.o_rv_wdata  = r_rv_wdata;
    assign bus.o_rv_ds     = r_rv_ds;
    assign bus.o_rv_wstrb  = r_rv_wstrb;
    assign bus.o_mem_ready = r_mem_ready;
    assign bus.o_mem_rdata = r_mem_rdata;
    assign o_busy          = (r_state != IDLE);
    assign o_timeout       = r_timeout;

endmodule

// File: tb/tb_rv_sdram_requester.sv
// Directed bench for rv_sdram_requester: a behavioural arbiter answers toggles
// after a programmable delay and logs every request the requester issues.
module tb_rv_sdram_requester;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic        timeout;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    int unsigned tog_cnt   = 0;
    int unsigned kick_req  = 0;
    int unsigned kick_seen = 0;
    int unsigned arb_cnt   = 0;
    int unsigned arb_delay = 3;
    logic        arb_en    = 1'b1;
    logic        mon_prev  = 1'b0;
    logic [15:0] dout_lo   = '0;
    logic [15:0] dout_hi   = '0;

    logic [22:0] lg_addr  [0:7];
    logic        lg_word  [0:7];
    logic [1:0]  lg_ds    [0:7];
    logic [3:0]  lg_wstrb [0:7];
    logic [31:0] lg_wdata [0:7];

    rv_sdram_requester_if #(.ADDR_WIDTH(23)) bus ();

    rv_sdram_requester #(
        .TIMEOUT_CYCLES(1024),
        .ADDR_WIDTH(23)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .bus       (bus),
        .o_busy    (busy),
        .o_timeout (timeout)
    );

    always #5 clk = ~clk;

    // Arbiter model and request logger, both on the falling edge.
    initial begin
        bus.i_rv_req_ack = 1'b0;
        bus.i_rv_dout    = '0;
        forever begin
            @(negedge clk);
            if (bus.o_rv_req !== mon_prev) begin
                lg_addr[tog_cnt % 8]  = bus.o_rv_addr;
                lg_word[tog_cnt % 8]  = bus.o_rv_word;
                lg_ds[tog_cnt % 8]    = bus.o_rv_ds;
                lg_wstrb[tog_cnt % 8] = bus.o_rv_wstrb;
                lg_wdata[tog_cnt % 8] = bus.o_rv_wdata;
                tog_cnt++;
                mon_prev = bus.o_rv_req;
            end
            if (kick_req != kick_seen) begin
                kick_seen        = kick_req;
                bus.i_rv_req_ack = ~bus.i_rv_req_ack;
                arb_cnt          = 0;
            end else if (arb_en && !rst && (bus.o_rv_req !== bus.i_rv_req_ack)) begin
                arb_cnt++;
                if (arb_cnt >= arb_delay) begin
                    bus.i_rv_dout    = bus.o_rv_word ? dout_hi : dout_lo;
                    bus.i_rv_req_ack = ~bus.i_rv_req_ack;
                    arb_cnt          = 0;
                end
            end else begin
                arb_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [22:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.i_mem_valid = 1'b1;
        bus.i_mem_addr  = a;
        bus.i_mem_wdata = d;
        bus.i_mem_wstrb = s;
    endtask

    // Returns the cycle count with the cycle valid was presented counted as 1; 0 on expiry.
    task automatic wait_ready(input int unsigned limit, output int unsigned lat);
        lat = 0;
        for (int unsigned i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_mem_ready === 1'b1) begin
                lat = i + 1;
                break;
            end
        end
    endtask

    task automatic check_log(input string tag, input int unsigned idx, input logic [22:0] a,
                             input logic w, input logic [1:0] ds, input logic [3:0] s,
                             input logic [31:0] d);
        check({tag, "_addr"},  32'(lg_addr[idx % 8]),  32'(a));
        check({tag, "_word"},  32'(lg_word[idx % 8]),  32'(w));
        check({tag, "_ds"},    32'(lg_ds[idx % 8]),    32'(ds));
        check({tag, "_wstrb"}, 32'(lg_wstrb[idx % 8]), 32'(s));
        check({tag, "_wdata"}, lg_wdata[idx % 8],      d);
    endtask

    initial begin
        int unsigned base;
        int unsigned lat;
        int unsigned spins;

        bus.i_mem_valid = 1'b0;
        bus.i_mem_addr  = '0;
        bus.i_mem_wdata = '0;
        bus.i_mem_wstrb = '0;

        #1 rst = 1'b1;
        tick(2);
        check("rst_req",    32'(bus.o_rv_req),    32'd0);
        check("rst_ready",  32'(bus.o_mem_ready), 32'd0);
        check("rst_rdata",  bus.o_mem_rdata,      32'd0);
        check("rst_addr",   32'(bus.o_rv_addr),   32'd0);
        check("rst_word",   32'(bus.o_rv_word),   32'd0);
        check("rst_wdata",  bus.o_rv_wdata,       32'd0);
        check("rst_ds",     32'(bus.o_rv_ds),     32'd0);
        check("rst_wstrb",  32'(bus.o_rv_wstrb),  32'd0);
        check("rst_tmo",    32'(timeout),         32'd0);
        check("rst_busy",   32'(busy),            32'd1);

        rst = 1'b0;
        tick(1);
        check("sync_req",   32'(bus.o_rv_req),    32'd0);
        check("sync_idle",  32'(busy),            32'd0);

        // Ack toggling while idle must be ignored.
        arb_en = 1'b0;
        base   = tog_cnt;
        kick_req++;
        tick(3);
        check("idle_ack_busy", 32'(busy),         32'd0);
        check("idle_ack_tog",  tog_cnt - base,    32'd0);
        check("idle_ack_rdy",  32'(bus.o_mem_ready), 32'd0);
        kick_req++;
        tick(2);
        arb_en = 1'b1;

        // Full read, N = 3.
        dout_lo   = 16'hBEEF;
        dout_hi   = 16'hDEAD;
        arb_delay = 3;
        base      = tog_cnt;
        drive(23'h066000, 32'h0, 4'b0000);
        wait_ready(60, lat);
        check("rd_lat",   lat,                 32'd10);
        check("rd_rdata", bus.o_mem_rdata,     32'hDEADBEEF);
        bus.i_mem_valid = 1'b0;
        tick(1);
        check("rd_pulse", 32'(bus.o_mem_ready), 32'd0);
        check("rd_tog",   tog_cnt - base,      32'd2);
        check_log("rd_lo", base,     23'h066000, 1'b0, 2'b11, 4'b0000, 32'h0);
        check_log("rd_hi", base + 1, 23'h066000, 1'b1, 2'b11, 4'b0000, 32'h0);

        // Full write, N = 2; inputs scrambled after acceptance.
        arb_delay = 2;
        base      = tog_cnt;
        drive(23'h000102, 32'h12345678, 4'b1111);
        tick(1);
        drive(23'h7FFFFF, 32'hFFFFFFFF, 4'b0001);
        wait_ready(60, lat);
        check("wr_lat",   lat + 1,             32'd8);
        bus.i_mem_valid = 1'b0;
        tick(1);
        check("wr_pulse", 32'(bus.o_mem_ready), 32'd0);
        check("wr_tog",   tog_cnt - base,      32'd2);
        check_log("wr_lo", base,     23'h000100, 1'b0, 2'b11, 4'b0011, 32'h12345678);
        check_log("wr_hi", base + 1, 23'h000100, 1'b1, 2'b11, 4'b1100, 32'h12345678);

        // Upper-half-only write, N = 3.
        arb_delay = 3;
        base      = tog_cnt;
        drive(23'h000204, 32'hAABBCCDD, 4'b0100);
        wait_ready(60, lat);
        check("wh_lat",   lat,                 32'd6);
        bus.i_mem_valid = 1'b0;
        tick(1);
        check("wh_tog",   tog_cnt - base,      32'd1);
        check_log("wh", base, 23'h000204, 1'b1, 2'b01, 4'b0100, 32'hAABBCCDD);

        // Back-to-back: valid stays high through DONE; second accepted only in IDLE.
        arb_delay = 1;
        dout_lo   = 16'h1111;
        dout_hi   = 16'h2222;
        base      = tog_cnt;
        drive(23'h000010, 32'h0, 4'b0000);
        wait_ready(60, lat);
        check("b2b_a_lat",   lat,              32'd6);
        check("b2b_a_rdata", bus.o_mem_rdata,  32'h22221111);
        drive(23'h000020, 32'h00005555, 4'b0011);
        wait_ready(60, lat);
        check("b2b_b_lat",   lat,              32'd5);
        bus.i_mem_valid = 1'b0;
        tick(1);
        check("b2b_pulse",   32'(bus.o_mem_ready), 32'd0);
        check("b2b_tog",     tog_cnt - base,   32'd3);
        check_log("b2b_b", base + 2, 23'h000020, 1'b0, 2'b11, 4'b0011, 32'h00005555);

        // Reset while WAIT_HI is outstanding, with ack toggling during reset.
        arb_delay = 50;
        base      = tog_cnt;
        drive(23'h000040, 32'h0, 4'b0000);
        spins = 0;
        while ((tog_cnt - base < 2) && (spins < 400)) begin
            tick(1);
            spins++;
        end
        check("rs_reach_hi", tog_cnt - base, 32'd2);
        tick(3);
        check("rs_busy_hi", 32'(busy), 32'd1);
        rst = 1'b1;
        bus.i_mem_valid = 1'b0;
        kick_req++;
        tick(2);
        kick_req++;
        tick(2);
        if (bus.i_rv_req_ack !== 1'b1) begin
            kick_req++;
            tick(2);
        end
        check("rs_req_in_rst", 32'(bus.o_rv_req), 32'd0);
        rst = 1'b0;
        tick(1);
        check("rs_sync_req",   32'(bus.o_rv_req), 32'd1);
        tick(1);
        check("rs_idle",       32'(busy),         32'd0);
        arb_delay = 3;
        dout_lo   = 16'h0A0B;
        dout_hi   = 16'h0C0D;
        base      = tog_cnt;
        drive(23'h000080, 32'h0, 4'b0000);
        wait_ready(60, lat);
        check("rs_rd_lat",   lat,             32'd10);
        check("rs_rd_rdata", bus.o_mem_rdata, 32'h0C0D0A0B);
        bus.i_mem_valid = 1'b0;
        tick(1);
        check("rs_rd_tog",   tog_cnt - base,  32'd2);

        // Timeout: ack withheld for 1100 wait cycles on a low-half write.
        arb_delay = 1100;
        base      = tog_cnt;
        drive(23'h000100, 32'h0000CAFE, 4'b0001);
        tick(1025);
        check("tmo_before", 32'(timeout), 32'd0);
        tick(1);
        check("tmo_rise",   32'(timeout), 32'd1);
        wait_ready(200, lat);
        check("tmo_lat",    lat + 1026,   32'd1103);
        bus.i_mem_valid = 1'b0;
        tick(5);
        check("tmo_sticky", 32'(timeout), 32'd1);
        check("tmo_tog",    tog_cnt - base, 32'd1);
        check("tmo_idle",   32'(busy),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv_sdram_requester.md
Name: rv_sdram_requester

Overview:
- Initiator side of the RISC-V softcore's toggle-handshake port into the SDRAM arbiter: i_rv_addr/i_rv_word/i_rv_wdata/i_rv_ds/i_rv_wstrb/i_rv_req in, o_rv_dout/o_rv_req_ack out.
- Accepts 32-bit valid/ready memory transactions from the softcore bus.
- Splits each transaction into 16-bit halfword requests and drives the toggle req/ack protocol.
- Reassembles read data and returns a single-cycle ready pulse to the CPU.

Parameters:
TIMEOUT_CYCLES, 1024, cycles a halfword request may stay outstanding before o_timeout sets
ADDR_WIDTH, 23, width of byte address on both sides

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous active-high reset
i_mem_valid  input  1  CPU transaction request; held until o_mem_ready
i_mem_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored
i_mem_wdata  input  32  write data
i_mem_wstrb  input  4  byte strobes; 0 = read
o_mem_ready  output  1  one-cycle completion pulse
o_mem_rdata  output  32  read data, valid with o_mem_ready
o_rv_addr  output  ADDR_WIDTH  address to arbiter ([1:0] forced 0)
o_rv_word  output  1  halfword select: 0 = low [15:0], 1 = high [31:16]
o_rv_wdata  output  32  write data to arbiter (full word; arbiter selects half)
o_rv_ds  output  2  byte enables of the selected halfword
o_rv_wstrb  output  4  strobes of the current halfword only (other half zeroed); 0 for reads
o_rv_req  output  1  request toggle
i_rv_req_ack  input  1  acknowledge toggle from arbiter
i_rv_dout  input  16  halfword read data
o_busy  output  1  high in any state except IDLE
o_timeout  output  1  sticky; set when a request exceeds TIMEOUT_CYCLES

Behaviour:
- Interface: one clock (i_clk); reset i_reset is asynchronous, active-high.
- Reset values: o_rv_req=0, o_mem_ready=0, o_mem_rdata=0, o_rv_addr=0, o_rv_word=0, o_rv_wdata=0, o_rv_ds=0, o_rv_wstrb=0, o_timeout=0, state=SYNC.
- Toggle protocol:
  - Request outstanding iff o_rv_req != i_rv_req_ack.
  - Issue a request by inverting o_rv_req; o_rv_addr/o_rv_word/o_rv_wdata/o_rv_ds/o_rv_wstrb are registered in the same cycle and held stable while outstanding.
  - Completion = first cycle with i_rv_req_ack == o_rv_req. i_rv_dout is captured in that cycle.
- States:
  - SYNC: o_rv_req <= i_rv_req_ack, then -> IDLE. Recovers from reset mid-operation with the arbiter's ack already toggled.
  - IDLE: on i_mem_valid, latch addr/wdata/wstrb.
    - Read (wstrb==0): -> REQ_LO.
    - Write with wstrb[1:0]!=0: -> REQ_LO.
    - Write with only wstrb[3:2]!=0: -> REQ_HI.
  - REQ_LO: drive word=0, ds=wstrb[1:0] (read: 2'b11), toggle req -> WAIT_LO.
  - WAIT_LO: on completion, rdata[15:0] <= i_rv_dout. Then -> REQ_HI if read or wstrb[3:2]!=0, else -> DONE.
  - REQ_HI: drive word=1, ds=wstrb[3:2] (read: 2'b11), toggle req -> WAIT_HI.
  - WAIT_HI: on completion, rdata[31:16] <= i_rv_dout, -> DONE.
  - DONE: o_mem_ready=1 for exactly one cycle, -> IDLE. i_mem_valid seen in DONE is not accepted; it is accepted next cycle in IDLE.
- Latency, ack arriving N cycles after the toggle:
  - Full read / both-half write: 2N+4 cycles from valid to ready.
  - Single-half write: N+3 cycles.
- Timeout:
  - 16-bit counter clears on each toggle and increments in WAIT_*.
  - Reaching TIMEOUT_CYCLES sets o_timeout (sticky until reset).
  - The state machine keeps waiting; there is no abort, because the toggle protocol cannot be cancelled.
- Ack change while nothing is outstanding (IDLE) is ignored; no state change.
- i_mem_* changes while busy are ignored; the latched copies are used.
- Unaligned bits addr[1:0] are zeroed on o_rv_addr.

Test Plan:
- Read 0x066000, arbiter acks after 3 cycles with 0xBEEF (low) then 0xDEAD (high) -> two req toggles with word=0 then 1, ds=2'b11; o_mem_rdata=0xDEADBEEF; ready pulse 10 cycles after valid.
- Write wdata=0x12345678, wstrb=4'b1111 -> two requests: word=0 with wstrb=4'b0011, then word=1 with wstrb=4'b1100; single ready pulse.
- Write wstrb=4'b0100 -> exactly one request, word=1, ds=2'b01, o_rv_wstrb=4'b0100; ready N+3 cycles after valid.
- Assert reset while in WAIT_HI, with ack toggling during reset; release -> SYNC sets o_rv_req equal to ack; a following read completes normally with no spurious request.
- Withhold ack for 1100 cycles -> o_timeout rises at cycle 1024 and stays high; a late ack still completes the transaction and ready pulses.
- Back-to-back valids -> second transaction is accepted only in IDLE after the DONE cycle; o_rv_req toggles exactly once per halfword.
